pipe_reg_chain: RTL and testbench
=================================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 32, payload width per stage.
REQ-002 Parameter STAGES, default 3, number of register stages (legal 1..8).
REQ-003 Parameter CNT_W, default 16, width of the performance counters.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous reset, active-low.
REQ-007 in_valid  input  1  stage-0 input carries a real instruction.
REQ-008 in_data  input  WIDTH  stage-0 payload.
REQ-009 stall_mask  input  STAGES  bit i: hazard unit requests stage i hold.
REQ-010 flush_mask  input  STAGES  bit i: stage i is squashed this cycle.
REQ-011 out_valid  output  1  valid bit of the last stage.
REQ-012 out_data  output  WIDTH  payload of the last stage.
REQ-013 stage_valid  output  STAGES  valid bit of every stage, for hazard detection.
REQ-014 stall_cnt  output  CNT_W  cycles in which any stage was held.
REQ-015 bubble_cnt  output  CNT_W  bubbles inserted by stall or flush.

Function
REQ-016 Each stage i SHALL hold a valid bit and a WIDTH-bit payload; stage 0 loads from in_valid/in_data, stage i>0 from stage i-1.
REQ-017 Effective hold h[i] SHALL be the OR of stall_mask[j] for all j >= i, so a downstream stall freezes every upstream stage.
REQ-018 A stage with h[i]=1 and flush_mask[i]=0 SHALL keep its valid bit and payload unchanged.
REQ-019 A stage i>0 with h[i]=0 and h[i-1]=1 SHALL load a bubble (valid=0, payload=0).
REQ-020 flush_mask[i]=1 SHALL load a bubble into stage i, overriding stall and normal advance.
REQ-021 Otherwise a stage SHALL load its upstream value; latency from in_* to out_* SHALL be exactly STAGES cycles with no stalls.
REQ-022 Outputs out_valid, out_data, stage_valid SHALL be driven directly from registers; no combinational path from any input.
REQ-023 stall_cnt SHALL increment by 1 in every cycle where any h[i]=1.
REQ-024 bubble_cnt SHALL increment by 1 in every cycle where at least one stage loads a bubble per REQ-019 or REQ-020 while its source or current content was valid; a squashed or generated bubble over an already-invalid stage SHALL not count.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-026 Payload of a stage with valid=0 SHALL always be 0.

Reset
REQ-027 While reset=0 at a rising edge, every valid bit, payload, stall_cnt and bubble_cnt SHALL become 0.
REQ-028 reset SHALL take priority over stall_mask and flush_mask; in-flight data is discarded.
REQ-029 First data load after reset release SHALL occur on the first rising edge with reset=1.

Structure
REQ-030 Package pipe_pkg SHALL hold MAX_STAGES=8 and the stage control typedef (enum HOLD, ADVANCE, BUBBLE).
REQ-031 One sub-module pipe_stage SHALL implement a single valid+payload register taking the control enum; pipe_reg_chain instantiates STAGES copies via generate.
REQ-032 Hold/bubble decode and counters SHALL live in pipe_reg_chain.

Verification (WIDTH=8, STAGES=3, CNT_W=4)
REQ-033 Stream 0x11,0x22,0x33 valid, no stall -> out_data 0x11 at cycle 3, 0x22 at 4, 0x33 at 5, out_valid=1 each.
REQ-034 Full pipe 0x11/0x22/0x33, stall_mask=3'b010 one cycle -> stages 0,1 hold, stage 2 gets bubble, out_valid=0 next cycle, stall_cnt=1, bubble_cnt=1.
REQ-035 Full pipe, stall_mask=3'b010 and flush_mask=3'b010 same cycle -> stage 1 becomes bubble, stage 0 holds, stage 2 bubble, bubble_cnt=2.
REQ-036 Stall held 20 cycles -> stall_cnt saturates at 15 and stays 15.
REQ-037 reset=0 for one cycle mid-stream with stall_mask=3'b111 -> all stage_valid=0, counters 0; next input appears at out 3 cycles after release.
REQ-038 flush_mask=3'b111 on empty pipe -> all stages stay invalid, bubble_cnt stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared limits and per-stage control encoding for the register chain
package pipe_pkg;
  localparam int unsigned MAX_STAGES = 8;
  typedef enum logic [1:0] {HOLD, ADVANCE, BUBBLE} stage_ctl_e;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+payload register steered by a hold/advance/bubble control
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  stage_ctl_e       ctl,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);
  always_ff @(posedge clk) begin
    if (!reset || ctl == BUBBLE) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (ctl == ADVANCE) begin
      q_valid <= d_valid;
      q_data  <= d_valid ? d_data : '0;
    end
  end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: stallable/flushable register pipeline with stall and bubble counters
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] stall_mask,
  input  logic [STAGES-1:0] flush_mask,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic [MAX_STAGES-1:0] sm, h, hu;
  logic [STAGES-1:0]     src_v, cur_v, bub_ev;
  logic [WIDTH-1:0]      src_d [STAGES];
  logic [WIDTH-1:0]      q_d   [STAGES];
  stage_ctl_e            ctl   [STAGES];
  // A stall anywhere downstream freezes every stage above it.
  always_comb begin
    sm = MAX_STAGES'(stall_mask);
    h  = sm;
    for (int i = MAX_STAGES - 2; i >= 0; i--) h[i] = sm[i] | h[i+1];
    hu = h << 1;
  end
  always_comb begin
    src_v    = (cur_v << 1) | STAGES'(in_valid);
    src_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) src_d[i] = q_d[i-1];
    for (int i = 0; i < STAGES; i++) begin
      ctl[i]    = flush_mask[i] ? BUBBLE : h[i] ? HOLD : hu[i] ? BUBBLE : ADVANCE;
      bub_ev[i] = (ctl[i] == BUBBLE) && (cur_v[i] || src_v[i]);
    end
  end
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .ctl     (ctl[g]),
      .d_valid (src_v[g]),
      .d_data  (src_d[g]),
      .q_valid (cur_v[g]),
      .q_data  (q_d[g])
    );
  end
  assign stage_valid = cur_v;
  assign out_valid   = cur_v[STAGES-1];
  assign out_data    = q_d[STAGES-1];
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (|h && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (|bub_ev && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed stimulus checked against a behavioural pipeline model
module tb_pipe_reg_chain;
  localparam int S = 3, CMAX = 15;
  logic       clk = 0, reset = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic [2:0] stall_mask = 0, flush_mask = 0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] stage_valid;
  logic [3:0] stall_cnt, bubble_cnt;
  int checks = 0, errors = 0;
  bit         mv [S];
  logic [7:0] md [S];
  int m_stall = 0, m_bub = 0;
  bit go = 0;

  pipe_reg_chain #(.WIDTH(8), .STAGES(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .stall_mask(stall_mask), .flush_mask(flush_mask), .out_valid(out_valid),
    .out_data(out_data), .stage_valid(stage_valid), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the furthest stalled stage k and everything above it freeze,
  // stage k+1 receives a bubble, and a flush always wins.
  always @(posedge clk) begin
    bit         nv [S];
    logic [7:0] nd [S];
    int k;
    bit bub, sv;
    logic [7:0] sd;
    go = 1;
    if (!reset) begin
      for (int i = 0; i < S; i++) begin mv[i] = 0; md[i] = 0; end
      m_stall = 0;
      m_bub = 0;
    end else begin
      k = -1;
      for (int j = 0; j < S; j++) if (stall_mask[j]) k = j;
      bub = 0;
      for (int i = 0; i < S; i++) begin
        sv = (i == 0) ? in_valid : mv[(i > 0) ? i - 1 : 0];
        sd = (i == 0) ? in_data : md[(i > 0) ? i - 1 : 0];
        if (flush_mask[i] || (k >= 0 && i == k + 1)) begin
          nv[i] = 0; nd[i] = 0;
          if (mv[i] || sv) bub = 1;
        end else if (i <= k) begin
          nv[i] = mv[i]; nd[i] = md[i];
        end else begin
          nv[i] = sv; nd[i] = sv ? sd : 8'h00;
        end
      end
      for (int i = 0; i < S; i++) begin mv[i] = nv[i]; md[i] = nd[i]; end
      if (k >= 0 && m_stall < CMAX) m_stall++;
      if (bub && m_bub < CMAX) m_bub++;
    end
  end

  always @(negedge clk) begin
    logic [2:0] svm;
    if (go) begin
      for (int i = 0; i < S; i++) svm[i] = mv[i];
      chk("model out_valid", out_valid, mv[S-1]);
      chk("model out_data", out_data, md[S-1]);
      chk("model stage_valid", stage_valid, svm);
      chk("model stall_cnt", stall_cnt, m_stall);
      chk("model bubble_cnt", bubble_cnt, m_bub);
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                     input logic [2:0] s, input logic [2:0] f);
    reset = r; in_valid = v; in_data = d; stall_mask = s; flush_mask = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset stage_valid", stage_valid, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset bubble_cnt", bubble_cnt, 0);
    cyc(1, 1, 8'h11, 0, 0);
    cyc(1, 1, 8'h22, 0, 0);
    cyc(1, 1, 8'h33, 0, 0);
    chk("latency out 11", out_data, 8'h11);
    chk("latency valid", out_valid, 1);
    cyc(1, 1, 8'h44, 0, 0);
    chk("stream out 22", out_data, 8'h22);
    cyc(1, 1, 8'h55, 0, 0);
    chk("stream out 33", out_data, 8'h33);
    cyc(1, 1, 8'h11, 0, 0);
    cyc(1, 1, 8'h22, 0, 0);
    cyc(1, 1, 8'h33, 0, 0);
    chk("full pipe valid", stage_valid, 3'b111);
    cyc(1, 0, 0, 3'b010, 0);
    chk("stall stage_valid", stage_valid, 3'b011);
    chk("stall out_valid", out_valid, 0);
    chk("stall stall_cnt", stall_cnt, 1);
    chk("stall bubble_cnt", bubble_cnt, 1);
    cyc(1, 1, 8'h44, 0, 0);
    chk("refill out 22", out_data, 8'h22);
    cyc(1, 0, 0, 3'b010, 3'b010);
    chk("flush+stall stage_valid", stage_valid, 3'b001);
    chk("flush+stall bubble_cnt", bubble_cnt, 2);
    repeat (20) cyc(1, 0, 0, 3'b100, 0);
    chk("stall sat", stall_cnt, 15);
    repeat (3) cyc(1, 0, 0, 3'b100, 0);
    chk("stall sat hold", stall_cnt, 15);
    repeat (16) cyc(1, 1, 8'h5a, 0, 3'b001);
    chk("bubble sat", bubble_cnt, 15);
    cyc(1, 1, 8'h61, 0, 0);
    cyc(1, 1, 8'h62, 0, 0);
    cyc(1, 1, 8'h63, 0, 0);
    cyc(0, 1, 8'h66, 3'b111, 0);
    chk("midreset stage_valid", stage_valid, 0);
    chk("midreset stall_cnt", stall_cnt, 0);
    chk("midreset bubble_cnt", bubble_cnt, 0);
    cyc(1, 1, 8'h77, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("release not yet", out_valid, 0);
    cyc(1, 0, 0, 0, 0);
    chk("release out 77", out_data, 8'h77);
    chk("release valid", out_valid, 1);
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("drained", stage_valid, 0);
    cyc(1, 0, 0, 0, 3'b111);
    cyc(1, 0, 0, 0, 3'b111);
    chk("empty flush valid", stage_valid, 0);
    chk("empty flush bubble_cnt", bubble_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
